// File: rtl/uart_spi_loader_if.sv
// UART/SPI/CPU-reset signal bundle for the UART-driven SPI loader.
// Handshake: an RX byte is consumed when uart_data_rx_ack pulses for one cycle; a response is valid for exactly the one cycle uart_have_data_tx is high.
interface uart_spi_loader_if #(
    parameter int NUM_CS = 2
);
    logic [7:0]        uart_data_rx;
    logic              uart_have_data_rx;
    logic              uart_data_rx_ack;
    logic [7:0]        uart_data_tx;
    logic              uart_have_data_tx;
    logic              uart_transmitting;
    logic [11:0]       uart_divider;
    logic [7:0]        spi_data_tx;
    logic [7:0]        spi_data_rx;
    logic              spi_txn_start;
    logic              spi_txn_done;
    logic [NUM_CS-1:0] spi_ce_n;
    logic              cpu_reset_req;

    modport master (
        input  uart_data_rx, uart_have_data_rx, uart_transmitting, spi_data_rx, spi_txn_done,
        output uart_data_rx_ack, uart_data_tx, uart_have_data_tx, uart_divider,
               spi_data_tx, spi_txn_start, spi_ce_n, cpu_reset_req
    );

    modport slave (
        output uart_data_rx, uart_have_data_rx, uart_transmitting, spi_data_rx, spi_txn_done,
        input  uart_data_rx_ack, uart_data_tx, uart_have_data_tx, uart_divider,
               spi_data_tx, spi_txn_start, spi_ce_n, cpu_reset_req
    );
endinterface

// File: rtl/uart_spi_loader.sv
// Byte-command loader: UART commands drive SPI chip selects, byte transfers,
// the UART divider and a CPU reset request; every accepted command byte gets one response.
module uart_spi_loader #(
    parameter int          NUM_CS      = 2,
    parameter int          COUNT_BYTES = 2,
    parameter logic [11:0] DIV_RESET   = 12'd434,
    parameter int          TIMEOUT     = 50_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                active,
    uart_spi_loader_if.master   bus,
    output logic [1:0]          dbg_state_o
);
    localparam int          CW       = 8 * COUNT_BYTES;
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
    localparam logic [7:0]  R_OK     = 8'h71;
    localparam logic [7:0]  R_ERR    = 8'h45;

    typedef enum logic [1:0] {
        S_CMD       = 2'd0,
        S_ARG       = 2'd1,
        S_WAIT_DATA = 2'd2,
        S_WAIT_SPI  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       timer_q, timer_d;
    logic [11:0]       div_q, div_d;
    logic [NUM_CS-1:0] ce_n_q, ce_n_d;
    logic [7:0]        spi_tx_q, spi_tx_d;
    logic [7:0]        resp_q, resp_d;
    logic              resp_vld_q, resp_vld_d;
    logic              ack_q, ack_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              start_q, start_d;
    logic              spi_phase_q, spi_phase_d;
    logic              arg_div_q, arg_div_d;
    logic              arg_idx_q, arg_idx_d;
    logic [15:0]       arg_buf_q, arg_buf_d;

    logic        accept;
    logic        sel_ok;
    logic        arg_last;
    logic [15:0] arg_full;
    logic [7:0]  rx;

    assign rx = bus.uart_data_rx;
    // A pending response or the previous cycle's ack keeps the next byte waiting.
    assign accept = active && bus.uart_have_data_rx && !bus.uart_transmitting &&
                    !resp_vld_q && (state_q != S_WAIT_SPI) && !ack_q;
    assign arg_last = arg_div_q ? arg_idx_q : ((COUNT_BYTES == 1) || arg_idx_q);

    always_comb begin
        arg_full = arg_buf_q;
        if (arg_idx_q) arg_full[15:8] = rx;
        else           arg_full[7:0]  = rx;
        sel_ok = 1'b0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (rx[3:0] == 4'(i)) sel_ok = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        timer_d     = timer_q;
        div_d       = div_q;
        ce_n_d      = ce_n_q;
        spi_tx_d    = spi_tx_q;
        resp_d      = resp_q;
        resp_vld_d  = resp_vld_q;
        ack_d       = ack_q;
        cpu_rst_d   = cpu_rst_q;
        start_d     = start_q;
        spi_phase_d = spi_phase_q;
        arg_div_d   = arg_div_q;
        arg_idx_d   = arg_idx_q;
        arg_buf_d   = arg_buf_q;
        if (active) begin
            resp_vld_d = 1'b0;
            ack_d      = 1'b0;
            cpu_rst_d  = 1'b0;
            if (accept) begin
                ack_d   = 1'b1;
                timer_d = '0;
            end
            case (state_q)
                S_CMD: begin
                    if (accept) begin
                        resp_vld_d = 1'b1;
                        resp_d     = R_ERR;
                        if (rx == 8'h70) begin
                            resp_d = 8'h50;
                        end else if (rx == 8'h52) begin
                            cpu_rst_d = 1'b1;
                            resp_d    = R_OK;
                        end else if ((rx[7:4] == 4'hC) || (rx[7:4] == 4'hD)) begin
                            if (sel_ok) begin
                                for (int i = 0; i < NUM_CS; i++) begin
                                    if (rx[3:0] == 4'(i)) ce_n_d[i] = rx[4];
                                end
                                resp_d = R_OK;
                            end
                        end else if ((rx == 8'h80) || (rx == 8'h90)) begin
                            state_d   = S_ARG;
                            arg_div_d = (rx == 8'h80);
                            arg_idx_d = 1'b0;
                            arg_buf_d = '0;
                            resp_d    = (rx == 8'h80) ? 8'h81 : 8'h91;
                        end
                    end
                end
                S_ARG, S_WAIT_DATA: begin
                    if (accept) begin
                        if (state_q == S_WAIT_DATA) begin
                            spi_tx_d    = rx;
                            start_d     = 1'b1;
                            spi_phase_d = 1'b0;
                            state_d     = S_WAIT_SPI;
                        end else if (!arg_last) begin
                            arg_buf_d = arg_full;
                            arg_idx_d = 1'b1;
                        end else begin
                            resp_vld_d = 1'b1;
                            state_d    = S_CMD;
                            if (arg_div_q) begin
                                div_d  = arg_full[11:0];
                                resp_d = R_OK;
                            end else if (arg_full[CW-1:0] != '0) begin
                                count_d = arg_full[CW-1:0];
                                resp_d  = 8'h92;
                                state_d = S_WAIT_DATA;
                            end else begin
                                resp_d = R_ERR;
                            end
                        end
                    end else if ((timer_q >= TMO_LAST) && !resp_vld_q) begin
                        resp_vld_d = 1'b1;
                        resp_d     = R_ERR;
                        ce_n_d     = '1;
                        state_d    = S_CMD;
                        timer_d    = '0;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
                S_WAIT_SPI: begin
                    // Two phases: see the slave go busy (done low), then wait for done.
                    if (!spi_phase_q) begin
                        if (!bus.spi_txn_done) begin
                            start_d     = 1'b0;
                            spi_phase_d = 1'b1;
                        end
                    end else if (bus.spi_txn_done) begin
                        resp_vld_d = 1'b1;
                        resp_d     = bus.spi_data_rx;
                        if (count_q != '0) count_d = count_q - CW'(1);
                        if (count_q <= CW'(1)) begin
                            state_d = S_CMD;
                        end else begin
                            state_d = S_WAIT_DATA;
                            timer_d = '0;
                        end
                    end
                end
                default: state_d = S_CMD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_CMD;
            count_q     <= '0;
            timer_q     <= '0;
            div_q       <= DIV_RESET;
            ce_n_q      <= '1;
            spi_tx_q    <= 8'h00;
            resp_q      <= 8'h00;
            resp_vld_q  <= 1'b0;
            ack_q       <= 1'b0;
            cpu_rst_q   <= 1'b0;
            start_q     <= 1'b0;
            spi_phase_q <= 1'b0;
            arg_div_q   <= 1'b0;
            arg_idx_q   <= 1'b0;
            arg_buf_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            div_q       <= div_d;
            ce_n_q      <= ce_n_d;
            spi_tx_q    <= spi_tx_d;
            resp_q      <= resp_d;
            resp_vld_q  <= resp_vld_d;
            ack_q       <= ack_d;
            cpu_rst_q   <= cpu_rst_d;
            start_q     <= start_d;
            spi_phase_q <= spi_phase_d;
            arg_div_q   <= arg_div_d;
            arg_idx_q   <= arg_idx_d;
            arg_buf_q   <= arg_buf_d;
        end
    end

    // Pulses stay registered while inactive and are masked at the output.
    assign bus.uart_data_rx_ack  = ack_q & active;
    assign bus.uart_have_data_tx = resp_vld_q & active;
    assign bus.cpu_reset_req     = cpu_rst_q & active;
    assign bus.uart_data_tx      = resp_q;
    assign bus.uart_divider      = div_q;
    assign bus.spi_data_tx       = spi_tx_q;
    assign bus.spi_txn_start     = start_q;
    assign bus.spi_ce_n          = ce_n_q;
    assign dbg_state_o           = state_q;
endmodule

// File: tb/tb_uart_spi_loader.sv
// Directed bench for uart_spi_loader: UART byte driver, SPI slave model,
// response monitor and an expected-response queue.
module tb_uart_spi_loader;
    logic       clk;
    logic       rst_n;
    logic       active;
    logic [1:0] dbg_state;

    uart_spi_loader_if #(.NUM_CS(2)) bus();

    uart_spi_loader #(
        .NUM_CS(2), .COUNT_BYTES(2), .DIV_RESET(12'd434), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .active(active), .bus(bus), .dbg_state_o(dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cpu_cnt = 0;
    int start_cnt = 0;
    logic prev_start = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] spi_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish (got time limit, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor samples outputs shortly after each active edge.
    always @(posedge clk) begin
        #1;
        if (bus.uart_have_data_tx) got_q.push_back(bus.uart_data_tx);
        if (bus.cpu_reset_req) cpu_cnt++;
        if (bus.spi_txn_start && !prev_start) start_cnt++;
        prev_start = bus.spi_txn_start;
    end

    // SPI slave: goes busy one cycle after start, returns the next queued byte.
    initial begin
        bus.spi_txn_done = 1'b1;
        bus.spi_data_rx  = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.spi_txn_start) begin
                @(negedge clk);
                bus.spi_txn_done = 1'b0;
                for (int k = 0; k < 50 && bus.spi_txn_start; k++) @(negedge clk);
                repeat (3) @(negedge clk);
                bus.spi_data_rx  = (spi_q.size() > 0) ? spi_q.pop_front() : 8'h00;
                bus.spi_txn_done = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        bus.uart_data_rx      = b;
        bus.uart_have_data_rx = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.uart_data_rx_ack && n < 200);
        if (!bus.uart_data_rx_ack) check("ack_timeout", 16'h0, 16'h1);
        bus.uart_have_data_rx = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic [7:0] e;
        int n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = 0;
            while (got_q.size() == 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (got_q.size() == 0) check({tag, "_timeout"}, 16'hFFFF, {8'h00, e});
            else                   check(tag, {8'h00, got_q.pop_front()}, {8'h00, e});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        active = 1'b1;
        bus.uart_data_rx = 8'h00;
        bus.uart_have_data_rx = 1'b0;
        bus.uart_transmitting = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_divider", {4'h0, bus.uart_divider}, 16'd434);
        check("rst_ce_n", {14'h0, bus.spi_ce_n}, 16'h3);
        check("rst_uart_tx", {8'h0, bus.uart_data_tx}, 16'h0);
        check("rst_spi_tx", {8'h0, bus.spi_data_tx}, 16'h0);
        check("rst_pulses", {12'h0, bus.spi_txn_start, bus.uart_have_data_tx,
                             bus.uart_data_rx_ack, bus.cpu_reset_req}, 16'h0);
        check("rst_state", {14'h0, dbg_state}, 16'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ping and chip selects
        send_byte(8'h70); exp_q.push_back(8'h50);
        send_byte(8'hC1); exp_q.push_back(8'h71);
        drain("ping");
        check("ce_after_c1", {14'h0, bus.spi_ce_n}, 16'h1);
        send_byte(8'hD1); exp_q.push_back(8'h71);
        drain("desel");
        check("ce_after_d1", {14'h0, bus.spi_ce_n}, 16'h3);
        send_byte(8'hC5); exp_q.push_back(8'h45);
        drain("bad_sel");
        check("ce_after_c5", {14'h0, bus.spi_ce_n}, 16'h3);
        send_byte(8'h52); exp_q.push_back(8'h71);
        drain("cpu_rst");
        check("cpu_rst_pulses", 16'(cpu_cnt), 16'd1);
        send_byte(8'h33); exp_q.push_back(8'h45);
        drain("unknown");

        // Divider, including masking to 12 bits
        send_byte(8'h80); send_byte(8'h64); send_byte(8'h00);
        exp_q.push_back(8'h81); exp_q.push_back(8'h71);
        drain("div100");
        check("divider_100", {4'h0, bus.uart_divider}, 16'd100);
        send_byte(8'h80); send_byte(8'h34); send_byte(8'hF2);
        exp_q.push_back(8'h81); exp_q.push_back(8'h71);
        drain("div_mask");
        check("divider_mask", {4'h0, bus.uart_divider}, 16'h0234);

        // Three-byte transfer
        spi_q.push_back(8'hA5); spi_q.push_back(8'h5A); spi_q.push_back(8'hFF);
        send_byte(8'h90); send_byte(8'h03); send_byte(8'h00);
        exp_q.push_back(8'h91); exp_q.push_back(8'h92);
        drain("xfer_hdr");
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(8'hFF);
        drain("xfer_echo");
        repeat (2) @(negedge clk);
        check("xfer_state", {14'h0, dbg_state}, 16'h0);
        check("xfer_spi_tx", {8'h0, bus.spi_data_tx}, 16'h33);
        check("xfer_starts", 16'(start_cnt), 16'd3);

        // Zero count
        send_byte(8'h90); send_byte(8'h00); send_byte(8'h00);
        exp_q.push_back(8'h91); exp_q.push_back(8'h45);
        drain("zero_cnt");
        repeat (4) @(negedge clk);
        check("zero_starts", 16'(start_cnt), 16'd3);
        check("zero_state", {14'h0, dbg_state}, 16'h0);

        // Timeout in WAIT_DATA
        send_byte(8'hC0); exp_q.push_back(8'h71);
        drain("sel0");
        send_byte(8'h90); send_byte(8'h01); send_byte(8'h00);
        exp_q.push_back(8'h91); exp_q.push_back(8'h92);
        drain("tmo_hdr");
        check("tmo_ce_before", {14'h0, bus.spi_ce_n}, 16'h2);
        repeat (10) @(negedge clk);
        check("tmo_early", 16'(got_q.size()), 16'd0);
        exp_q.push_back(8'h45);
        drain("tmo_resp");
        check("tmo_ce_after", {14'h0, bus.spi_ce_n}, 16'h3);
        check("tmo_state", {14'h0, dbg_state}, 16'h0);
        send_byte(8'h70); exp_q.push_back(8'h50);
        drain("tmo_ping");

        // Inactive: no timeout, no acceptance
        send_byte(8'h80); exp_q.push_back(8'h81);
        drain("hold_hdr");
        active = 1'b0;
        bus.uart_data_rx = 8'h10;
        bus.uart_have_data_rx = 1'b1;
        repeat (30) @(negedge clk);
        bus.uart_have_data_rx = 1'b0;
        check("hold_no_resp", 16'(got_q.size()), 16'd0);
        check("hold_state", {14'h0, dbg_state}, 16'h1);
        active = 1'b1;
        send_byte(8'h10); send_byte(8'h00); exp_q.push_back(8'h71);
        drain("hold_resume");
        check("hold_divider", {4'h0, bus.uart_divider}, 16'd16);

        // Reset while waiting on SPI
        spi_q.push_back(8'hEE);
        send_byte(8'h90); send_byte(8'h02); send_byte(8'h00);
        exp_q.push_back(8'h91); exp_q.push_back(8'h92);
        drain("mid_hdr");
        send_byte(8'h44);
        check("mid_in_spi", {14'h0, dbg_state}, 16'h3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_no_resp", 16'(got_q.size()), 16'd0);
        check("mid_state", {14'h0, dbg_state}, 16'h0);
        check("mid_divider", {4'h0, bus.uart_divider}, 16'd434);
        check("mid_start", {15'h0, bus.spi_txn_start}, 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
